ds_cic_decimator: RTL and testbench



---
 rtl/ds_pkg.sv | 19 +
 rtl/ds_cic_decimator_comb.sv | 63 ++++++
 rtl/ds_cic_decimator.sv | 64 ++++++
 tb/tb_ds_cic_decimator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared delta-sigma definitions: code width, CIC order, code decode and
// CIC internal width helper. Also used by the modulator side.
package ds_pkg;

    localparam int DS_CODE_W = 4;
    localparam int CIC_ORDER = 3;

    // Sign-magnitude code to two's complement; 4'b1000 decodes to 0.
    function automatic logic signed [DS_CODE_W-1:0] ds_decode(input logic [DS_CODE_W-1:0] code);
        logic signed [DS_CODE_W-1:0] mag;
        mag = {1'b0, code[DS_CODE_W-2:0]};
        return code[DS_CODE_W-1] ? -mag : mag;
    endfunction

    function automatic int cic_int_w(input int log2_decim);
        return DS_CODE_W + CIC_ORDER * log2_decim;
    endfunction

endpackage

// File: rtl/ds_cic_decimator_comb.sv
// Three-stage CIC comb plus the valid/ready output register with sticky overrun.
module ds_cic_comb
    import ds_pkg::*;
#(
    parameter int INT_W = 16,
    parameter int OUT_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dec,
    input  logic signed [INT_W-1:0] i3,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    overrun
);

    localparam int SHIFT = (INT_W > OUT_W) ? INT_W - OUT_W : 0;

    logic signed [INT_W-1:0] d1, d2, d3, c1, c2, c3;
    logic signed [OUT_W-1:0] y, y_next;
    logic                    y_vld;

    always_comb begin
        c1     = i3 - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        y_next = OUT_W'(c3 >>> SHIFT);
    end

    // y/y_vld is a one-stage hold between the comb and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            y         <= '0;
            y_vld     <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            y_vld <= dec;
            if (dec) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                y  <= y_next;
            end
            if (y_vld) begin
                if (!out_valid || out_ready) begin
                    data_out  <= y;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ds_cic_decimator.sv
// sinc^3 decimator for the 4-bit delta-sigma stream: decode, integrators and
// phase counter here; comb and output handshake in ds_cic_comb.
module ds_cic_decimator
    import ds_pkg::*;
#(
    parameter  int DECIM      = 16,
    parameter  int OUT_W      = 14,
    localparam int LOG2_DECIM = $clog2(DECIM),
    localparam int INT_W      = cic_int_w(LOG2_DECIM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DS_CODE_W-1:0]    ds_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    overrun
);

    logic signed [DS_CODE_W-1:0] xd;
    logic signed [INT_W-1:0]     x, i1, i2, i3, i1_n, i2_n, i3_n;
    logic [LOG2_DECIM-1:0]       cnt;
    logic                        dec;

    // Integrators chain within one cycle; wrap-around is intentional.
    always_comb begin
        xd   = ds_decode(ds_in);
        x    = {{(INT_W-DS_CODE_W){xd[DS_CODE_W-1]}}, xd};
        i1_n = i1 + x;
        i2_n = i2 + i1_n;
        i3_n = i3 + i2_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
            dec <= 1'b0;
        end else begin
            dec <= in_valid && (cnt == LOG2_DECIM'(DECIM - 1));
            if (in_valid) begin
                i1  <= i1_n;
                i2  <= i2_n;
                i3  <= i3_n;
                cnt <= cnt + 1'b1;
            end
        end
    end

    ds_cic_comb #(.INT_W(INT_W), .OUT_W(OUT_W)) u_comb (
        .clk       (clk),
        .reset     (reset),
        .dec       (dec),
        .i3        (i3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_ds_cic_decimator.sv
// Scoreboard bench for ds_cic_decimator: stimulus pushes hand-computed samples,
// a negedge monitor pops and compares on every transfer.
module tb_ds_cic_decimator;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [3:0]        ds_in = 4'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [13:0] data_out;
    logic              overrun;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ds_cic_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ds_in     (ds_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .overrun   (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_sample: got %0d, expected none", int'(data_out));
            end else begin
                check("sample", int'(data_out), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Feed n accepted codes; gaps inserts random idle cycles.
    task automatic feed(input logic [3:0] code, input int n, input bit gaps);
        int k = 0;
        while (k < n) begin
            ds_in    = code;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            #1;
            if (in_valid) k++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_data_out", int'(data_out), 0);
        check("reset_overrun", int'(overrun), 0);

        // Positive step, with latency check on the first sample.
        out_ready = 1'b1;
        exp_q.push_back(1428);
        feed(4'b0111, 16, 1'b0);
        check("lat_edge0", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_edge1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_edge2", int'(out_valid), 1);
        check("lat_data", int'(data_out), 1428);
        exp_q.push_back(6188); exp_q.push_back(7168); exp_q.push_back(7168);
        feed(4'b0111, 48, 1'b0);
        drain("drain_pos");

        // Negative full scale.
        do_reset();
        exp_q.push_back(-1428); exp_q.push_back(-6188); exp_q.push_back(-7168);
        exp_q.push_back(-7168);
        feed(4'b1111, 64, 1'b0);
        drain("drain_neg");

        // Zero codes, including negative zero.
        do_reset();
        repeat (3) exp_q.push_back(0);
        feed(4'b0000, 48, 1'b0);
        repeat (3) exp_q.push_back(0);
        feed(4'b1000, 48, 1'b0);
        drain("drain_zero");

        // Long run with gaps: integrators wrap many times.
        do_reset();
        exp_q.push_back(1428); exp_q.push_back(6188);
        repeat (623) exp_q.push_back(7168);
        feed(4'b0111, 10000, 1'b1);
        drain("drain_wrap");
        check("wrap_overrun", int'(overrun), 0);

        // Backpressure across two strobes: second sample dropped.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(1428);
        feed(4'b0111, 32, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid", int'(out_valid), 1);
        check("bp_hold", int'(data_out), 1428);
        check("bp_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_cleared", int'(out_valid), 0);
        check("bp_sticky", int'(overrun), 1);
        drain("drain_bp");

        // Ready raised exactly on the load cycle: back-to-back, no overrun.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(1428);
        feed(4'b0111, 16, 1'b0);
        feed(4'b0111, 16, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("sim_valid", int'(out_valid), 1);
        check("sim_data", int'(data_out), 6188);
        check("sim_overrun", int'(overrun), 0);
        exp_q.push_back(6188);
        out_ready = 1'b1;
        drain("drain_sim");

        // Reset mid-frame discards partial input.
        do_reset();
        feed(4'b0111, 7, 1'b0);
        do_reset();
        exp_q.push_back(1428); exp_q.push_back(6188); exp_q.push_back(7168);
        feed(4'b0111, 48, 1'b0);
        drain("drain_midrst");
        check("midrst_overrun", int'(overrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
